// File: rtl/proc_mem.sv
`default_nettype none
// ============================================================================
// Module      : proc_mem
// Description : Word-addressed dual-read RAM answering instruction fetches and
//               data loads/stores, with an OUT port, a cycle counter, a
//               sticky out-of-range flag and a bench preload port.
// Revision    : 1.0 - initial release
// ============================================================================
module proc_mem #(
    parameter int WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imemreq_val,
    input  logic [31:0] imemreq_addr,
    output logic [31:0] imemresp_data,
    input  logic        dmemreq_val,
    input  logic        dmemreq_type,
    input  logic [31:0] dmemreq_addr,
    input  logic [31:0] dmemreq_wdata,
    output logic [31:0] dmemresp_rdata,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        out_val,
    output logic [31:0] out_data,
    output logic [31:0] cycles,
    output logic        err
);

    localparam int          c_AW       = $clog2(WORDS);
    localparam logic [31:0] c_OUT_ADDR = 32'h0000_2000;
    localparam logic [31:0] c_CYC_ADDR = 32'h0000_2004;

    logic [31:0] r_mem [WORDS];
    logic [31:0] r_out_data;
    logic [31:0] r_cycles;
    logic        r_out_val;
    logic        r_err;

    logic            w_i_ram, w_d_ram, w_l_ram;
    logic [c_AW-1:0] w_i_idx, w_d_idx, w_l_idx;
    logic            w_d_out, w_d_cyc, w_d_oor;
    logic            w_ld, w_st, w_err_evt;
    logic            w_unused;

    // RAM occupies every address whose bits above the word index are zero.
    assign w_i_ram = (imemreq_addr[31:c_AW+2] == '0);
    assign w_d_ram = (dmemreq_addr[31:c_AW+2] == '0);
    assign w_l_ram = (load_addr[31:c_AW+2] == '0);
    assign w_i_idx = imemreq_addr[c_AW+1:2];
    assign w_d_idx = dmemreq_addr[c_AW+1:2];
    assign w_l_idx = load_addr[c_AW+1:2];

    assign w_d_out = (dmemreq_addr[31:2] == c_OUT_ADDR[31:2]);
    assign w_d_cyc = (dmemreq_addr[31:2] == c_CYC_ADDR[31:2]);
    assign w_d_oor = !w_d_ram && !w_d_out && !w_d_cyc;

    assign w_ld = dmemreq_val && !dmemreq_type;
    assign w_st = dmemreq_val && dmemreq_type;

    // Fetches never decode MMIO, so anything outside RAM is an error for them.
    assign w_err_evt = (imemreq_val && !w_i_ram) || (dmemreq_val && w_d_oor);

    assign w_unused = &{1'b0, imemreq_addr[1:0], dmemreq_addr[1:0], load_addr[1:0]};

    always_comb begin
        imemresp_data = '0;
        if (imemreq_val && w_i_ram)
            imemresp_data = r_mem[w_i_idx];
    end

    always_comb begin
        dmemresp_rdata = '0;
        if (w_ld) begin
            if (w_d_ram)
                dmemresp_rdata = r_mem[w_d_idx];
            else if (w_d_out)
                dmemresp_rdata = r_out_data;
            else if (w_d_cyc)
                dmemresp_rdata = r_cycles;
        end
    end

    // Array is not reset; the preload write comes last so it wins a same-word clash.
    always_ff @(posedge clk) begin
        if (w_st && w_d_ram)
            r_mem[w_d_idx] <= dmemreq_wdata;
        if (load_en && w_l_ram)
            r_mem[w_l_idx] <= load_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_val  <= 1'b0;
            r_out_data <= '0;
            r_cycles   <= '0;
            r_err      <= 1'b0;
        end else begin
            r_out_val <= w_st && w_d_out;
            if (w_st && w_d_out)
                r_out_data <= dmemreq_wdata;
            r_cycles <= r_cycles + 32'd1;
            if (w_err_evt)
                r_err <= 1'b1;
        end
    end

    assign out_val  = r_out_val;
    assign out_data = r_out_data;
    assign cycles   = r_cycles;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_proc_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_proc_mem
// Description : Directed plus randomized bench for proc_mem against an
//               address-map level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_proc_mem;

    localparam int WORDS = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imemreq_val = 1'b0;
    logic [31:0] imemreq_addr = '0;
    logic [31:0] imemresp_data;
    logic        dmemreq_val = 1'b0;
    logic        dmemreq_type = 1'b0;
    logic [31:0] dmemreq_addr = '0;
    logic [31:0] dmemreq_wdata = '0;
    logic [31:0] dmemresp_rdata;
    logic        load_en = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data = '0;
    logic        out_val;
    logic [31:0] out_data;
    logic [31:0] cycles;
    logic        err;

    proc_mem #(.WORDS(WORDS)) dut (
        .clk(clk), .rst(rst),
        .imemreq_val(imemreq_val), .imemreq_addr(imemreq_addr), .imemresp_data(imemresp_data),
        .dmemreq_val(dmemreq_val), .dmemreq_type(dmemreq_type), .dmemreq_addr(dmemreq_addr),
        .dmemreq_wdata(dmemreq_wdata), .dmemresp_rdata(dmemresp_rdata),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .out_val(out_val), .out_data(out_data), .cycles(cycles), .err(err)
    );

    always #5 clk = ~clk;

    // Reference state
    logic [31:0] m_mem [WORDS];
    logic [31:0] m_out_data = '0;
    logic [31:0] m_cycles   = '0;
    logic        m_out_val  = 1'b0;
    logic        m_err      = 1'b0;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // 0 = RAM, 1 = OUT, 2 = CYC, 3 = out of range
    function automatic int region(input logic [31:0] a);
        if (a < 4 * WORDS)          return 0;
        if ((a >> 2) == 32'h800)    return 1;
        if ((a >> 2) == 32'h801)    return 2;
        return 3;
    endfunction

    function automatic logic [31:0] exp_fetch();
        if (imemreq_val && region(imemreq_addr) == 0)
            return m_mem[int'(imemreq_addr >> 2)];
        return 32'h0;
    endfunction

    function automatic logic [31:0] exp_load();
        if (!dmemreq_val || dmemreq_type) return 32'h0;
        case (region(dmemreq_addr))
            0:       return m_mem[int'(dmemreq_addr >> 2)];
            1:       return m_out_data;
            2:       return m_cycles;
            default: return 32'h0;
        endcase
    endfunction

    task automatic idle();
        imemreq_val = 1'b0; dmemreq_val = 1'b0; dmemreq_type = 1'b0; load_en = 1'b0;
    endtask

    // Let combinational paths settle, then compare every output with the model.
    task automatic settle();
        if (rst) begin
            m_out_val = 1'b0; m_out_data = '0; m_cycles = '0; m_err = 1'b0;
        end
        #1;
        check("fetch",    imemresp_data,  exp_fetch());
        check("load",     dmemresp_rdata, exp_load());
        check("out_val",  {31'b0, out_val}, {31'b0, m_out_val});
        check("out_data", out_data, m_out_data);
        check("cycles",   cycles,   m_cycles);
        check("err",      {31'b0, err}, {31'b0, m_err});
    endtask

    task automatic clock_edge();
        int r;
        @(posedge clk);
        r = region(dmemreq_addr);
        if (dmemreq_val && dmemreq_type && r == 0)
            m_mem[int'(dmemreq_addr >> 2)] = dmemreq_wdata;
        if (load_en && region(load_addr) == 0)
            m_mem[int'(load_addr >> 2)] = load_data;
        if (!rst) begin
            if ((imemreq_val && region(imemreq_addr) != 0) || (dmemreq_val && r == 3))
                m_err = 1'b1;
            m_out_val = dmemreq_val && dmemreq_type && r == 1;
            if (m_out_val) m_out_data = dmemreq_wdata;
            m_cycles = m_cycles + 32'd1;
        end
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        clock_edge();
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: return 32'($urandom_range(0, 4 * WORDS - 1));
            6:                return 32'h2000 | 32'($urandom_range(0, 3));
            7:                return 32'h2004 | 32'($urandom_range(0, 3));
            8:                return $urandom;
            default:          return 32'(4 * WORDS) + 32'($urandom_range(0, 64));
        endcase
    endfunction

    logic [31:0] old_val;

    initial begin
        // Reset state, before any edge
        #1;
        check("rst_out_val",  {31'b0, out_val}, 32'h0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_cycles",   cycles,   32'h0);
        check("rst_err",      {31'b0, err}, 32'h0);
        @(negedge clk);

        // Fill the RAM while still in reset; writes must land regardless.
        for (int i = 0; i < WORDS; i++) begin
            load_en = 1'b1; load_addr = 32'(i * 4); load_data = $urandom;
            step();
        end
        idle();

        rst = 1'b0;
        repeat (10) step();
        dmemreq_val = 1'b1; dmemreq_addr = 32'h2004;
        settle();
        check("cyc_after_10", dmemresp_rdata, 32'd10);
        clock_edge();
        idle();

        // Preload then same-cycle fetch, unaligned load
        load_en = 1'b1; load_addr = 32'h10; load_data = 32'hDEADBEEF;
        step();
        idle();
        imemreq_val = 1'b1; imemreq_addr = 32'h10;
        dmemreq_val = 1'b1; dmemreq_addr = 32'h13;
        settle();
        check("fetch_0x10", imemresp_data,  32'hDEADBEEF);
        check("load_0x13",  dmemresp_rdata, 32'hDEADBEEF);
        clock_edge();
        idle();

        // Read-during-write returns old data
        old_val = m_mem[8];
        dmemreq_val = 1'b1; dmemreq_type = 1'b1; dmemreq_addr = 32'h20; dmemreq_wdata = 32'h12345678;
        imemreq_val = 1'b1; imemreq_addr = 32'h20;
        settle();
        check("rdw_old", imemresp_data, old_val);
        clock_edge();
        idle();
        dmemreq_val = 1'b1; dmemreq_addr = 32'h20;
        settle();
        check("rdw_new", dmemresp_rdata, 32'h12345678);
        clock_edge();
        idle();

        // OUT port
        dmemreq_val = 1'b1; dmemreq_type = 1'b1; dmemreq_addr = 32'h2000; dmemreq_wdata = 32'd5;
        step();
        idle();
        settle();
        check("out_pulse", {31'b0, out_val}, 32'h1);
        check("out_data5", out_data, 32'd5);
        clock_edge();
        dmemreq_val = 1'b1; dmemreq_addr = 32'h2000;
        settle();
        check("out_drop", {31'b0, out_val}, 32'h0);
        check("out_hold", out_data, 32'd5);
        check("out_load", dmemresp_rdata, 32'd5);
        clock_edge();
        idle();

        // Counter wrap via preset
        force dut.r_cycles = 32'hFFFF_FFFE;
        #1;
        release dut.r_cycles;
        m_cycles = 32'hFFFF_FFFE;
        step();
        settle();
        check("cyc_max", cycles, 32'hFFFF_FFFF);
        clock_edge();
        settle();
        check("cyc_wrap", cycles, 32'h0);
        clock_edge();

        // Out-of-range and sticky err, then async reset
        dmemreq_val = 1'b1; dmemreq_addr = 32'h4000;
        settle();
        check("oor_rdata", dmemresp_rdata, 32'h0);
        clock_edge();
        idle();
        imemreq_val = 1'b1; imemreq_addr = 32'h2000;
        settle();
        check("err_set", {31'b0, err}, 32'h1);
        clock_edge();
        idle();
        #2;
        rst = 1'b1;
        #1;
        check("async_err",  {31'b0, err}, 32'h0);
        check("async_cyc",  cycles,   32'h0);
        check("async_out",  out_data, 32'h0);
        settle();
        clock_edge();
        rst = 1'b0;
        imemreq_val = 1'b1; imemreq_addr = 32'h10;
        settle();
        check("ram_kept", imemresp_data, 32'hDEADBEEF);
        clock_edge();
        idle();

        // Preload beats same-word store
        load_en = 1'b1; load_addr = 32'h30; load_data = 32'd1;
        dmemreq_val = 1'b1; dmemreq_type = 1'b1; dmemreq_addr = 32'h30; dmemreq_wdata = 32'd2;
        step();
        idle();
        dmemreq_val = 1'b1; dmemreq_addr = 32'h30;
        settle();
        check("preload_wins", dmemresp_rdata, 32'd1);
        clock_edge();
        idle();

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            rst           = ($urandom_range(0, 59) == 0);
            imemreq_val   = $urandom_range(0, 3) != 0;
            imemreq_addr  = rand_addr();
            dmemreq_val   = $urandom_range(0, 3) != 0;
            dmemreq_type  = $urandom_range(0, 1) == 1;
            dmemreq_addr  = rand_addr();
            dmemreq_wdata = $urandom;
            load_en       = $urandom_range(0, 4) == 0;
            load_addr     = ($urandom_range(0, 1) == 1) ? dmemreq_addr : rand_addr();
            load_data     = $urandom;
            step();
        end
        rst = 1'b0;
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
